// File: rtl/vcve2_pkg.sv
// -----------------------------------------------------------------------------
// vcve2_pkg
// Shared types for the vector issue controller:
//   ctl_state_t : issue FSM states (idle / request in flight / watchdog error)
//   vinstr_t    : one queued vector instruction (operands, destination,
//                 operand count, write-back enable)
// VAddrWidth sets the stored width of register addresses. The controller
// casts its AddrWidth ports to and from this width.
// -----------------------------------------------------------------------------
package vcve2_pkg;

  localparam int unsigned VAddrWidth = 5;

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'd0,
    CTL_BUSY  = 2'd1,
    CTL_ERROR = 2'd2
  } ctl_state_t;

  typedef struct packed {
    logic [VAddrWidth-1:0] vs1;
    logic [VAddrWidth-1:0] vs2;
    logic [VAddrWidth-1:0] vd;
    logic [1:0]            num_operands;
    logic                  wr_en;
  } vinstr_t;

endpackage

// File: rtl/vinstr_fifo.sv
// -----------------------------------------------------------------------------
// vinstr_fifo
// Instruction queue for vector_issue_ctrl. The head entry stays in the queue
// while it is in flight and is removed by pop_i.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   push_i, data_i        write one entry (ignored when full or flushing)
//   pop_i                 remove the head (ignored when empty)
//   flush_all_i           drop every entry
//   flush_keep_head_i     drop everything except the head
//   head_o                entry at the read pointer
//   full_o, empty_o       occupancy flags
//   empty_next_o          queue will be empty after this clock edge
// Depth must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module vinstr_fifo
  import vcve2_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  vinstr_t data_i,
  input  logic    pop_i,
  input  logic    flush_all_i,
  input  logic    flush_keep_head_i,
  output vinstr_t head_o,
  output logic    full_o,
  output logic    empty_o,
  output logic    empty_next_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  vinstr_t         mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  // Any flush wins over a push issued in the same cycle.
  assign push_ok = push_i && !full_o && !flush_all_i && !flush_keep_head_i;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_all_i) begin
      wptr_d = rptr_q;
      cnt_d  = '0;
    end else if (flush_keep_head_i) begin
      if (empty_o) begin
        cnt_d = '0;
      end else if (pop_ok) begin
        // Head completes in the same cycle: nothing survives.
        rptr_d = rptr_q + 1'b1;
        wptr_d = rptr_q + 1'b1;
        cnt_d  = '0;
      end else begin
        wptr_d = rptr_q + 1'b1;
        cnt_d  = CntW'(1);
      end
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  assign empty_next_o = (cnt_d == '0);
  assign head_o       = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; consumers only look at the head while it is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/vector_issue_ctrl.sv
// -----------------------------------------------------------------------------
// vector_issue_ctrl
// Queues vector instructions and issues them one at a time to the vector
// register file stage, holding each request until a completion pulse.
// A watchdog traps a request that never completes into a sticky error state.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   instr_valid_i / instr_ready_o  instruction handshake
//   vs1_i, vs2_i, vd_i             operand / destination addresses
//   num_operands_i, wr_en_i        operand count, write-back enable
//   flush_i                        drop queued, not-yet-issued instructions
//   vrf_req_o, vrf_we_o            request / write enable to the VRF stage
//   vrf_raddr_a_o, vrf_raddr_b_o,
//   vrf_waddr_o, vrf_num_operands_o  fields of the instruction in flight
//   vector_done_i                  one-cycle completion pulse
//   busy_o                         queue non-empty or not idle
//   timeout_o                      sticky watchdog error (cleared by reset)
// -----------------------------------------------------------------------------
module vector_issue_ctrl
  import vcve2_pkg::*;
#(
  parameter int unsigned AddrWidth     = 5,
  parameter int unsigned QueueDepth    = 2,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [AddrWidth-1:0] vs1_i,
  input  logic [AddrWidth-1:0] vs2_i,
  input  logic [AddrWidth-1:0] vd_i,
  input  logic [1:0]           num_operands_i,
  input  logic                 wr_en_i,
  input  logic                 flush_i,
  output logic                 vrf_req_o,
  output logic                 vrf_we_o,
  output logic [AddrWidth-1:0] vrf_raddr_a_o,
  output logic [AddrWidth-1:0] vrf_raddr_b_o,
  output logic [AddrWidth-1:0] vrf_waddr_o,
  output logic [1:0]           vrf_num_operands_o,
  input  logic                 vector_done_i,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int unsigned WdW = $clog2(TimeoutCycles + 1);

  ctl_state_t     state_q, state_d;
  logic [WdW-1:0] wdog_q, wdog_d;

  vinstr_t push_data;
  vinstr_t head;
  logic    fifo_push;
  logic    fifo_pop;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_empty_next;

  assign push_data.vs1          = VAddrWidth'(vs1_i);
  assign push_data.vs2          = VAddrWidth'(vs2_i);
  assign push_data.vd           = VAddrWidth'(vd_i);
  assign push_data.num_operands = num_operands_i;
  assign push_data.wr_en        = wr_en_i;

  assign timeout_o     = (state_q == CTL_ERROR);
  assign instr_ready_o = !fifo_full && !timeout_o;
  assign fifo_push     = instr_valid_i && instr_ready_o;
  // Completion pulses outside BUSY never reach the queue.
  assign fifo_pop      = vector_done_i && (state_q == CTL_BUSY);

  vinstr_fifo #(
    .Depth(QueueDepth)
  ) u_fifo (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .push_i           (fifo_push),
    .data_i           (push_data),
    .pop_i            (fifo_pop),
    .flush_all_i      (flush_i && (state_q == CTL_IDLE)),
    .flush_keep_head_i(flush_i && (state_q == CTL_BUSY)),
    .head_o           (head),
    .full_o           (fifo_full),
    .empty_o          (fifo_empty),
    .empty_next_o     (fifo_empty_next)
  );

  // The FSM looks at next-cycle occupancy so that an instruction pushed into
  // an empty queue is requested on the very next cycle, and a pop with more
  // entries behind it keeps the request high without an idle gap.
  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      CTL_IDLE: begin
        if (!fifo_empty_next) begin
          state_d = CTL_BUSY;
          wdog_d  = '0;
        end
      end
      CTL_BUSY: begin
        if (vector_done_i) begin
          if (fifo_empty_next) begin
            state_d = CTL_IDLE;
          end else begin
            wdog_d = '0;  // new head issued back-to-back
          end
        end else if (wdog_q == WdW'(TimeoutCycles - 1)) begin
          // Counter reaches TimeoutCycles on this edge and parks there.
          state_d = CTL_ERROR;
          wdog_d  = WdW'(TimeoutCycles);
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      CTL_ERROR: begin
        state_d = CTL_ERROR;
      end
      default: begin
        state_d = CTL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CTL_IDLE;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  // Fields are gated by the request so the un-reset queue storage never
  // shows up on the outputs.
  assign vrf_req_o          = (state_q == CTL_BUSY);
  assign vrf_we_o           = vrf_req_o && head.wr_en;
  assign vrf_raddr_a_o      = vrf_req_o ? AddrWidth'(head.vs1) : '0;
  assign vrf_raddr_b_o      = vrf_req_o ? AddrWidth'(head.vs2) : '0;
  assign vrf_waddr_o        = vrf_req_o ? AddrWidth'(head.vd) : '0;
  assign vrf_num_operands_o = vrf_req_o ? head.num_operands : 2'b00;
  assign busy_o             = (state_q != CTL_IDLE) || !fifo_empty;

endmodule
